lane_dly_step_ctrl: RTL and testbench

- Delay-line step sequencer directly upstream of the DDR4 PHY lane controller. It converts a single training request into the exact DELAY_LINE_SEL / LOAD / DIRECTION / MOVE / HS_IO_CLK_PAUSE pulse sequence the lane controller needs.
- It monitors RX/TX out-of-range flags and reports completion status to the training engine.
- One instance per lane, in the FAB_CLK domain.

---
 rtl/lane_dly_step_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_lane_dly_step_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_dly_step_ctrl.sv
// Per-lane delay-line step sequencer: turns one training request into the PAUSE/LOAD/MOVE pulse train.
// Optional tap-position tracking with clamp-based out-of-range: define LANE_DLY_TAP_TRACK_EN.
module lane_dly_step_ctrl #(
    parameter int PAUSE_SETUP = 4,
    parameter int MOVE_GAP    = 2,
    parameter int SETTLE      = 8
`ifdef LANE_DLY_TAP_TRACK_EN
    ,
    parameter int TAP_MAX     = 255
`endif
) (
    input  logic       FAB_CLK,
    input  logic       RESET,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_SEL,
    input  logic       REQ_LOAD,
    input  logic       REQ_DIR,
    input  logic [7:0] REQ_STEPS,
    input  logic       RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic       TX_DELAY_LINE_OUT_OF_RANGE,
    output logic       DELAY_LINE_SEL,
    output logic       DELAY_LINE_LOAD,
    output logic       DELAY_LINE_DIRECTION,
    output logic       DELAY_LINE_MOVE,
    output logic       HS_IO_CLK_PAUSE,
    output logic       DONE,
    output logic       DONE_OOR,
    output logic [7:0] STEPS_DONE
`ifdef LANE_DLY_TAP_TRACK_EN
    ,
    output logic [7:0] RX_TAP_POS,
    output logic [7:0] TX_TAP_POS
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_LOAD,
        S_MOVE,
        S_GAP,
        S_SETTLE
    } state_e;

    state_e     state_q;
    logic [7:0] cnt_q;
    logic       sel_q;
    logic       dir_q;
    logic       load_q;
    logic [7:0] steps_q;
    logic [7:0] issued_q;
    logic       oor_q;
    logic       ready_q;
    logic       pause_q;
    logic       ld_q;
    logic       mv_q;
    logic       done_q;
    logic       done_oor_q;
    logic [7:0] steps_done_q;

    logic       accept;
    logic       oor_sel;
    logic       clamp_oor;
    logic [7:0] issued_d;

    assign accept   = REQ_VALID && ready_q && (state_q == S_IDLE);
    // Only the flag of the delay line actually being moved matters.
    assign oor_sel  = sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;
    assign issued_d = (issued_q == 8'hFF) ? issued_q : issued_q + 8'd1;

    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            sel_q        <= 1'b0;
            dir_q        <= 1'b0;
            load_q       <= 1'b0;
            steps_q      <= 8'd0;
            issued_q     <= 8'd0;
            oor_q        <= 1'b0;
            ready_q      <= 1'b1;
            pause_q      <= 1'b0;
            ld_q         <= 1'b0;
            mv_q         <= 1'b0;
            done_q       <= 1'b0;
            done_oor_q   <= 1'b0;
            steps_done_q <= 8'd0;
        end else begin
            ld_q   <= 1'b0;
            mv_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q      <= S_PRE;
                        cnt_q        <= 8'(PAUSE_SETUP - 1);
                        ready_q      <= 1'b0;
                        pause_q      <= 1'b1;
                        sel_q        <= REQ_SEL;
                        dir_q        <= REQ_DIR;
                        load_q       <= REQ_LOAD;
                        steps_q      <= REQ_STEPS;
                        issued_q     <= 8'd0;
                        oor_q        <= 1'b0;
                        done_oor_q   <= 1'b0;
                        steps_done_q <= 8'd0;
                    end
                end
                S_PRE: begin
                    if (cnt_q == 8'd0) begin
                        if (load_q) begin
                            state_q <= S_LOAD;
                            ld_q    <= 1'b1;
                        end else if (steps_q != 8'd0) begin
                            state_q  <= S_MOVE;
                            mv_q     <= 1'b1;
                            issued_q <= issued_d;
                        end else begin
                            state_q <= S_SETTLE;
                            cnt_q   <= 8'(SETTLE - 1);
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_LOAD: begin
                    state_q <= S_SETTLE;
                    cnt_q   <= 8'(SETTLE - 1);
                end
                S_MOVE: begin
                    if (issued_q < steps_q) begin
                        state_q <= S_GAP;
                        cnt_q   <= 8'(MOVE_GAP - 1);
                    end else begin
                        state_q <= S_SETTLE;
                        cnt_q   <= 8'(SETTLE - 1);
                    end
                end
                S_GAP: begin
                    if (oor_sel) begin
                        oor_q   <= 1'b1;
                        state_q <= S_SETTLE;
                        cnt_q   <= 8'(SETTLE - 1);
                    end else if (cnt_q == 8'd0) begin
                        state_q  <= S_MOVE;
                        mv_q     <= 1'b1;
                        issued_q <= issued_d;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_SETTLE: begin
                    if (oor_sel) oor_q <= 1'b1;
                    // Leaving SETTLE: the DONE cycle is already IDLE, so a held request re-accepts here.
                    if (cnt_q == 8'd0) begin
                        state_q      <= S_IDLE;
                        pause_q      <= 1'b0;
                        ready_q      <= 1'b1;
                        done_q       <= 1'b1;
                        done_oor_q   <= oor_q | oor_sel | clamp_oor;
                        steps_done_q <= issued_q;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    pause_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef LANE_DLY_TAP_TRACK_EN
    logic [7:0] rx_tap_q;
    logic [7:0] tx_tap_q;
    logic       clamp_q;
    logic [7:0] tap_cur;
    logic [7:0] tap_d;
    logic       tap_hit;

    assign tap_cur = sel_q ? tx_tap_q : rx_tap_q;
    assign tap_hit = dir_q ? (tap_cur >= 8'(TAP_MAX)) : (tap_cur == 8'd0);
    assign tap_d   = dir_q ? tap_cur + 8'd1 : tap_cur - 8'd1;

    // Position follows the pulse one cycle later; a blocked move is remembered for DONE_OOR.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            rx_tap_q <= 8'd0;
            tx_tap_q <= 8'd0;
            clamp_q  <= 1'b0;
        end else begin
            if (accept) clamp_q <= 1'b0;
            if (ld_q) begin
                if (sel_q) tx_tap_q <= 8'd1;
                else       rx_tap_q <= 8'd1;
            end else if (mv_q) begin
                if (tap_hit)    clamp_q  <= 1'b1;
                else if (sel_q) tx_tap_q <= tap_d;
                else            rx_tap_q <= tap_d;
            end
        end
    end

    assign clamp_oor  = clamp_q;
    assign RX_TAP_POS = rx_tap_q;
    assign TX_TAP_POS = tx_tap_q;
`else
    assign clamp_oor = 1'b0;
`endif

    assign REQ_READY            = ready_q;
    assign DELAY_LINE_SEL       = sel_q;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign DELAY_LINE_LOAD      = ld_q;
    assign DELAY_LINE_MOVE      = mv_q;
    assign HS_IO_CLK_PAUSE      = pause_q;
    assign DONE                 = done_q;
    assign DONE_OOR             = done_oor_q;
    assign STEPS_DONE           = steps_done_q;

endmodule

// File: tb/tb_lane_dly_step_ctrl.sv
// Directed bench for lane_dly_step_ctrl: pulse timing, load, out-of-range stop, reset abort, back-to-back.
module tb_lane_dly_step_ctrl;
    logic       FAB_CLK = 1'b0;
    logic       RESET;
    logic       REQ_VALID, REQ_READY, REQ_SEL, REQ_LOAD, REQ_DIR;
    logic [7:0] REQ_STEPS;
    logic       RX_DELAY_LINE_OUT_OF_RANGE, TX_DELAY_LINE_OUT_OF_RANGE;
    logic       DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE;
    logic       HS_IO_CLK_PAUSE, DONE, DONE_OOR;
    logic [7:0] STEPS_DONE;
`ifdef LANE_DLY_TAP_TRACK_EN
    logic [7:0] RX_TAP_POS, TX_TAP_POS;
`endif

    always #5 FAB_CLK = ~FAB_CLK;

    lane_dly_step_ctrl dut (
        .FAB_CLK                    (FAB_CLK),
        .RESET                      (RESET),
        .REQ_VALID                  (REQ_VALID),
        .REQ_READY                  (REQ_READY),
        .REQ_SEL                    (REQ_SEL),
        .REQ_LOAD                   (REQ_LOAD),
        .REQ_DIR                    (REQ_DIR),
        .REQ_STEPS                  (REQ_STEPS),
        .RX_DELAY_LINE_OUT_OF_RANGE (RX_DELAY_LINE_OUT_OF_RANGE),
        .TX_DELAY_LINE_OUT_OF_RANGE (TX_DELAY_LINE_OUT_OF_RANGE),
        .DELAY_LINE_SEL             (DELAY_LINE_SEL),
        .DELAY_LINE_LOAD            (DELAY_LINE_LOAD),
        .DELAY_LINE_DIRECTION       (DELAY_LINE_DIRECTION),
        .DELAY_LINE_MOVE            (DELAY_LINE_MOVE),
        .HS_IO_CLK_PAUSE            (HS_IO_CLK_PAUSE),
        .DONE                       (DONE),
        .DONE_OOR                   (DONE_OOR),
        .STEPS_DONE                 (STEPS_DONE)
`ifdef LANE_DLY_TAP_TRACK_EN
        ,
        .RX_TAP_POS                 (RX_TAP_POS),
        .TX_TAP_POS                 (TX_TAP_POS)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int inv_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // MOVE must never coincide with LOAD nor appear outside the pause window.
    always @(negedge FAB_CLK)
        if (RESET === 1'b0 && DELAY_LINE_MOVE === 1'b1 && (DELAY_LINE_LOAD !== 1'b0 || HS_IO_CLK_PAUSE !== 1'b1))
            inv_err++;

    typedef struct {
        int done_cyc;
        int moves;
        int loads;
        int load_cyc;
        int pause_cnt;
        int pause_first;
        int mv1, mv2, mv3;
        int steps_done;
        int done_oor;
        int sel_bad;
        int dir_bad;
    } res_t;

    // Cycle k = k-th cycle after the accept edge; sampled at the falling edge.
    task automatic run_req(input bit sel, input bit ld, input bit dir, input int steps,
                           input int oor_after, input int settle_pulse, input bit rx_tog,
                           input bit hold, output res_t r);
        int w;
        r = '{default: 0};
        r.done_cyc = -1;
        @(negedge FAB_CLK);
        REQ_VALID = 1'b1; REQ_SEL = sel; REQ_LOAD = ld; REQ_DIR = dir; REQ_STEPS = 8'(steps);
        w = 0;
        while (REQ_READY !== 1'b1 && w < 50) begin
            @(negedge FAB_CLK);
            w++;
        end
        chk("ready_before_req", REQ_READY, 1);
        @(negedge FAB_CLK);
        if (!hold) begin
            REQ_VALID = 1'b0; REQ_SEL = ~sel; REQ_LOAD = ~ld; REQ_DIR = ~dir; REQ_STEPS = ~8'(steps);
        end
        for (int k = 1; k <= 2000; k++) begin
            if (k == 1) r.pause_first = int'(HS_IO_CLK_PAUSE);
            if (HS_IO_CLK_PAUSE === 1'b1) r.pause_cnt++;
            if (DELAY_LINE_MOVE === 1'b1) begin
                r.moves++;
                if (r.moves == 1) r.mv1 = k;
                if (r.moves == 2) r.mv2 = k;
                if (r.moves == 3) r.mv3 = k;
            end
            if (DELAY_LINE_LOAD === 1'b1) begin
                r.loads++;
                r.load_cyc = k;
            end
            if (DELAY_LINE_SEL !== sel) r.sel_bad++;
            if (DELAY_LINE_DIRECTION !== dir) r.dir_bad++;
            if (DONE === 1'b1) begin
                r.done_cyc   = k;
                r.steps_done = int'(STEPS_DONE);
                r.done_oor   = int'(DONE_OOR);
                break;
            end
            if (oor_after >= 0 && r.moves == oor_after && DELAY_LINE_MOVE === 1'b1)
                TX_DELAY_LINE_OUT_OF_RANGE = 1'b1;
            if (rx_tog) RX_DELAY_LINE_OUT_OF_RANGE = ~RX_DELAY_LINE_OUT_OF_RANGE;
            if (settle_pulse > 0) RX_DELAY_LINE_OUT_OF_RANGE = (k == settle_pulse);
            @(negedge FAB_CLK);
        end
        TX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
        RX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
        if (r.done_cyc < 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        int   cnt;
        RESET = 1'b1; REQ_VALID = 1'b0; REQ_SEL = 1'b0; REQ_LOAD = 1'b0; REQ_DIR = 1'b0;
        REQ_STEPS = 8'd0; RX_DELAY_LINE_OUT_OF_RANGE = 1'b0; TX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
        repeat (3) @(negedge FAB_CLK);
        RESET = 1'b0;
        @(negedge FAB_CLK);
        chk("rst_ready", REQ_READY, 1);
        chk("rst_pause", HS_IO_CLK_PAUSE, 0);
        chk("rst_move", DELAY_LINE_MOVE, 0);
        chk("rst_done", DONE, 0);
        chk("rst_steps", STEPS_DONE, 0);

        // 3 increments on RX; inputs scrambled after accept must not matter
        run_req(1'b0, 1'b0, 1'b1, 3, -1, 0, 1'b0, 1'b0, r);
        chk("t1_pause_first", r.pause_first, 1);
        chk("t1_mv1", r.mv1, 5);
        chk("t1_mv2", r.mv2, 8);
        chk("t1_mv3", r.mv3, 11);
        chk("t1_moves", r.moves, 3);
        chk("t1_loads", r.loads, 0);
        chk("t1_pause_cnt", r.pause_cnt, 19);
        chk("t1_done_cyc", r.done_cyc, 20);
        chk("t1_steps_done", r.steps_done, 3);
        chk("t1_oor", r.done_oor, 0);
        chk("t1_sel", r.sel_bad, 0);
        chk("t1_dir", r.dir_bad, 0);
        @(negedge FAB_CLK);
        chk("t1_steps_held", STEPS_DONE, 3);

        // reload: steps ignored
        run_req(1'b0, 1'b1, 1'b0, 9, -1, 0, 1'b0, 1'b0, r);
        chk("t2_loads", r.loads, 1);
        chk("t2_load_cyc", r.load_cyc, 5);
        chk("t2_moves", r.moves, 0);
        chk("t2_pause_cnt", r.pause_cnt, 13);
        chk("t2_done_cyc", r.done_cyc, 14);
        chk("t2_steps_done", r.steps_done, 0);

        // TX out-of-range after 4th move, RX toggling is ignored
        run_req(1'b1, 1'b0, 1'b0, 10, 4, 0, 1'b1, 1'b0, r);
        chk("t3_moves", r.moves, 4);
        chk("t3_oor", r.done_oor, 1);
        chk("t3_steps_done", r.steps_done, 4);
        chk("t3_done_cyc", r.done_cyc, 24);
        chk("t3_sel", r.sel_bad, 0);

        // RX out-of-range seen only during settle
        run_req(1'b0, 1'b0, 1'b0, 1, -1, 8, 1'b0, 1'b0, r);
        chk("t5_moves", r.moves, 1);
        chk("t5_done_cyc", r.done_cyc, 14);
        chk("t5_oor", r.done_oor, 1);
        chk("t5_steps_done", r.steps_done, 1);

        // zero steps: pause window only; sticky OOR cleared by accept
        run_req(1'b0, 1'b0, 1'b1, 0, -1, 0, 1'b0, 1'b0, r);
        chk("t4_moves", r.moves, 0);
        chk("t4_loads", r.loads, 0);
        chk("t4_pause_cnt", r.pause_cnt, 12);
        chk("t4_done_cyc", r.done_cyc, 13);
        chk("t4_steps_done", r.steps_done, 0);
        chk("t4_oor", r.done_oor, 0);

        // reset at the 2nd MOVE aborts without DONE
        @(negedge FAB_CLK);
        REQ_VALID = 1'b1; REQ_SEL = 1'b1; REQ_LOAD = 1'b0; REQ_DIR = 1'b1; REQ_STEPS = 8'd5;
        @(negedge FAB_CLK);
        REQ_VALID = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (DELAY_LINE_MOVE === 1'b1) cnt++;
            if (cnt == 2) break;
            @(negedge FAB_CLK);
        end
        chk("t6_mv2_seen", cnt, 2);
        RESET = 1'b1;
        @(negedge FAB_CLK);
        RESET = 1'b0;
        chk("t6_ready", REQ_READY, 1);
        chk("t6_pause", HS_IO_CLK_PAUSE, 0);
        chk("t6_move", DELAY_LINE_MOVE, 0);
        chk("t6_sel", DELAY_LINE_SEL, 0);
        chk("t6_dir", DELAY_LINE_DIRECTION, 0);
        chk("t6_done", DONE, 0);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge FAB_CLK);
            if (DONE === 1'b1) cnt++;
        end
        chk("t6_no_done", cnt, 0);
        run_req(1'b0, 1'b0, 1'b1, 1, -1, 0, 1'b0, 1'b0, r);
        chk("t6_after_done_cyc", r.done_cyc, 14);
        chk("t6_after_steps", r.steps_done, 1);

        // maximum step count: 1+4+255+254*2+8
        run_req(1'b0, 1'b0, 1'b1, 255, -1, 0, 1'b0, 1'b0, r);
        chk("t7_moves", r.moves, 255);
        chk("t7_steps_done", r.steps_done, 255);
        chk("t7_done_cyc", r.done_cyc, 776);
        chk("t7_oor", r.done_oor, 0);

        // REQ_VALID held: second accept lands on the DONE cycle
        run_req(1'b0, 1'b0, 1'b0, 0, -1, 0, 1'b0, 1'b1, r);
        chk("t8_done_cyc", r.done_cyc, 13);
        @(negedge FAB_CLK);
        chk("t8_b2b_pause", HS_IO_CLK_PAUSE, 1);
        chk("t8_b2b_ready", REQ_READY, 0);
        REQ_VALID = 1'b0;
        cnt = 1;
        while (DONE !== 1'b1 && cnt < 100) begin
            @(negedge FAB_CLK);
            cnt++;
        end
        chk("t8_b2b_done_cyc", cnt, 13);

`ifdef LANE_DLY_TAP_TRACK_EN
        run_req(1'b1, 1'b1, 1'b1, 0, -1, 0, 1'b0, 1'b0, r);
        chk("tap_load", TX_TAP_POS, 1);
        run_req(1'b1, 1'b0, 1'b1, 255, -1, 0, 1'b0, 1'b0, r);
        chk("tap_first_pos", TX_TAP_POS, 255);
        run_req(1'b1, 1'b0, 1'b1, 45, -1, 0, 1'b0, 1'b0, r);
        chk("tap_second_oor", r.done_oor, 1);
        chk("tap_second_pos", TX_TAP_POS, 255);
        chk("tap_second_moves", r.moves, 45);
`endif

        chk("invariants", inv_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
